// File: rtl/vga_pkg.sv
// Shared timing constants and FSM encoding for the 640x480@60 raster generator.
package vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    DRAIN  = 2'b10
  } state_t;

endpackage

// File: rtl/vga_timing_ctrl_raster_counter.sv
// Enabled up-counter that wraps to zero after its terminal value; also exposes
// the next count so callers can decode registered outputs without extra latency.
module raster_counter #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] nxt,
  output logic          wrap
);

  always_comb begin
    wrap = en && (cnt == term);
    if (wrap) begin
      nxt = '0;
    end else if (en) begin
      nxt = cnt + 1'b1;
    end else begin
      nxt = cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel counters, active-low syncs, visible flag and
// frame/line markers, with run/stop control that only stops on frame boundaries.
module vga_timing_ctrl #(
  parameter int CW     = 10,
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          run,
  output logic          busy,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          frame_start,
  output logic          line_end,
  output logic [1:0]    state_dbg
);
  import vga_pkg::*;

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_TERM   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_TERM   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_VIS_C  = CW'(H_VIS);
  localparam logic [CW-1:0] V_VIS_C  = CW'(V_VIS);
  localparam logic [CW-1:0] HS_START = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_VIS + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_VIS + V_FP + V_SYNC);

  state_t        state, state_nxt;
  logic          h_en, h_wrap, v_wrap, frame_last;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          scan_nxt, fs_nxt, hs_nxt, vs_nxt, vo_nxt;

  // Counters only move while scanning; they are already at (0,0) whenever IDLE is entered.
  assign h_en       = pix_en && (state != IDLE);
  assign frame_last = h_wrap && v_wrap;
  assign state_dbg  = state;

  raster_counter #(.CW(CW)) u_hcnt (
    .clk  (clk),
    .rst  (rst),
    .en   (h_en),
    .term (H_TERM),
    .cnt  (hc),
    .nxt  (h_nxt),
    .wrap (h_wrap)
  );

  raster_counter #(.CW(CW)) u_vcnt (
    .clk  (clk),
    .rst  (rst),
    .en   (h_wrap),
    .term (V_TERM),
    .cnt  (vc),
    .nxt  (v_nxt),
    .wrap (v_wrap)
  );

  always_comb begin
    state_nxt = state;
    fs_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (pix_en && run) begin
          state_nxt = ACTIVE;
          fs_nxt    = 1'b1;
        end
      end
      ACTIVE: begin
        if (frame_last) begin
          if (run) fs_nxt = 1'b1;
          else     state_nxt = IDLE;
        end else if (pix_en && !run) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_last)          state_nxt = IDLE;
        else if (pix_en && run)  state_nxt = ACTIVE;
      end
      default: state_nxt = IDLE;
    endcase

    // Decode from the next counts so the registered flags line up with hc/vc.
    scan_nxt = (state_nxt != IDLE);
    hs_nxt   = !(scan_nxt && (h_nxt >= HS_START) && (h_nxt < HS_END));
    vs_nxt   = !(scan_nxt && (v_nxt >= VS_START) && (v_nxt < VS_END));
    vo_nxt   = scan_nxt && (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= scan_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      video_on    <= vo_nxt;
      frame_start <= fs_nxt;
      line_end    <= h_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size and a reduced-timing instance share stimulus
// and are checked every cycle against a pixel-index model of the raster.
module tb_vga_timing_ctrl;

  logic       clk, rst, pix_en, run;
  logic [9:0] hc0, vc0, hc1, vc1;
  logic       bz0, hs0, vs0, vo0, fs0, le0;
  logic       bz1, hs1, vs1, vo1, fs1, le1;
  logic [1:0] st0, st1;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  vga_timing_ctrl dut_full (
    .clk(clk), .rst(rst), .pix_en(pix_en), .run(run), .busy(bz0), .hc(hc0), .vc(vc0),
    .hsync(hs0), .vsync(vs0), .video_on(vo0), .frame_start(fs0), .line_end(le0),
    .state_dbg(st0)
  );

  vga_timing_ctrl #(
    .CW(10), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_small (
    .clk(clk), .rst(rst), .pix_en(pix_en), .run(run), .busy(bz1), .hc(hc1), .vc(vc1),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .frame_start(fs1), .line_end(le1),
    .state_dbg(st1)
  );

  // ---------------- behavioural model ----------------
  // Raster position is a linear pixel index p in [0, H_TOTAL*V_TOTAL).
  int th[2], tv[2], hv[2], vv[2], hsa[2], hse[2], vsa[2], vse[2];
  int p[2], fs_m[2], le_m[2];
  bit scan[2], stop[2];

  initial begin
    th[0] = 800; tv[0] = 525; hv[0] = 640; vv[0] = 480;
    hsa[0] = 656; hse[0] = 752; vsa[0] = 490; vse[0] = 492;
    th[1] = 16;  tv[1] = 9;   hv[1] = 8;   vv[1] = 4;
    hsa[1] = 10; hse[1] = 13; vsa[1] = 5;  vse[1] = 7;
    for (int i = 0; i < 2; i++) begin
      p[i] = 0; scan[i] = 0; stop[i] = 0; fs_m[i] = 0; le_m[i] = 0;
    end
  end

  task automatic model_step(input int i);
    bit last;
    fs_m[i] = 0;
    le_m[i] = 0;
    if (!rst) begin
      p[i] = 0; scan[i] = 0; stop[i] = 0;
    end else if (pix_en) begin
      if (!scan[i]) begin
        if (run) begin
          scan[i] = 1; stop[i] = 0; fs_m[i] = 1;
        end
      end else begin
        last    = (p[i] == th[i] * tv[i] - 1);
        le_m[i] = ((p[i] % th[i]) == th[i] - 1);
        p[i]    = (p[i] + 1) % (th[i] * tv[i]);
        if (last) begin
          if (stop[i] || !run) scan[i] = 0;
          else                 fs_m[i] = 1;
        end else begin
          stop[i] = !run;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: act=%0d exp=%0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [9:0] hc_a, input logic [9:0] vc_a,
                          input logic hs_a, input logic vs_a, input logic vo_a,
                          input logic bz_a, input logic fs_a, input logic le_a);
    int h, v;
    h = p[i] % th[i];
    v = p[i] / th[i];
    check($sformatf("hc[%0d]", i), hc_a, h);
    check($sformatf("vc[%0d]", i), vc_a, v);
    check($sformatf("hsync[%0d]", i), hs_a, !(scan[i] && h >= hsa[i] && h < hse[i]));
    check($sformatf("vsync[%0d]", i), vs_a, !(scan[i] && v >= vsa[i] && v < vse[i]));
    check($sformatf("video_on[%0d]", i), vo_a, scan[i] && h < hv[i] && v < vv[i]);
    check($sformatf("busy[%0d]", i), bz_a, scan[i]);
    check($sformatf("frame_start[%0d]", i), fs_a, fs_m[i]);
    check($sformatf("line_end[%0d]", i), le_a, le_m[i]);
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    cmp_inst(0, hc0, vc0, hs0, vs0, vo0, bz0, fs0, le0);
    cmp_inst(1, hc1, vc1, hs1, vs1, vo1, bz1, fs1, le1);
  end

  // ---------------- driver ----------------
  int pe_mode  = 0;
  int div      = 0;
  bit rand_run = 0;
  bit busy_dropped = 0;

  task automatic drive();
    if (pe_mode == 0) begin
      pix_en = (div == 0);
      div    = (div + 1) % 4;
    end else begin
      pix_en = ($urandom_range(0, 2) == 0);
    end
    if (rand_run && $urandom_range(0, 299) == 0) run = ~run;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      drive();
    end
  endtask

  // kind 0: small at (a,b); kind 1: small busy low; kind 2: small frame_start.
  // Returns just after a posedge with the condition true, or flags a timeout.
  task automatic wait_cond(input int kind, input int a, input int b, input string name);
    bit met;
    met = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #2;
      if (!bz1) busy_dropped = 1;
      case (kind)
        0: met = (hc1 == 10'(a)) && (vc1 == 10'(b));
        1: met = !bz1;
        default: met = fs1;
      endcase
      if (met) break;
      @(negedge clk);
      drive();
    end
    if (!met) check({"timeout_", name}, 0, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hc"}, hc1, 0);
    check({tag, "_vc"}, vc1, 0);
    check({tag, "_hsync"}, hs1, 1);
    check({tag, "_vsync"}, vs1, 1);
    check({tag, "_video_on"}, vo1, 0);
    check({tag, "_busy"}, bz1, 0);
    check({tag, "_frame_start"}, fs1, 0);
    check({tag, "_line_end"}, le1, 0);
    check({tag, "_hc_full"}, hc0, 0);
    check({tag, "_busy_full"}, bz0, 0);
  endtask

  int vo_cnt, le_cnt, fs_cnt, hs_lo_cnt, vo_full_cnt;

  initial begin
    rst = 1'b0; pix_en = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    cyc(1000);

    // Start: align run with a pixel-enable edge, then measure the first frame/line.
    do cyc(1); while (!pix_en);
    run = 1'b1;
    vo_cnt = 0; le_cnt = 0; fs_cnt = 0; hs_lo_cnt = 0; vo_full_cnt = 0;
    for (int s = 0; s < 3200; s++) begin
      @(posedge clk);
      #2;
      if (s == 0) begin
        check("start_frame_start", fs0, 1);
        check("start_busy", bz0, 1);
        check("start_hc", hc0, 0);
      end
      if (s == 1) check("start_pulse_width", fs0, 0);
      if (s == 4) check("start_hc_after_4", hc0, 1);
      if (s < 576) begin
        vo_cnt += vo1; le_cnt += le1; fs_cnt += fs1;
      end
      hs_lo_cnt   += !hs0;
      vo_full_cnt += vo0;
      @(negedge clk);
      drive();
    end
    check("small_frame_video_clks", vo_cnt, 128);
    check("small_frame_line_ends", le_cnt, 8);
    check("small_frame_starts", fs_cnt, 1);
    check("full_line_hsync_low_clks", hs_lo_cnt, 384);
    check("full_line_video_clks", vo_full_cnt, 2560);

    // Randomized pixel enables and run toggling.
    pe_mode = 1; rand_run = 1;
    cyc(6000);
    pe_mode = 0; rand_run = 0;

    // Stop mid-frame: scanning drains to the frame end, then idles.
    run = 1'b1;
    wait_cond(0, 5, 2, "stop_pos");
    @(negedge clk); run = 1'b0; drive();
    wait_cond(1, 0, 0, "drain_end");
    check("stop_hc", hc1, 0);
    check("stop_vc", vc1, 0);
    check("stop_final_line_end", le1, 1);
    check("stop_no_frame_start", fs1, 0);

    // Resume during drain: no interruption of busy.
    @(negedge clk); run = 1'b1; drive();
    wait_cond(0, 0, 1, "resume_run");
    busy_dropped = 0;
    @(negedge clk); run = 1'b0; drive();
    wait_cond(0, 0, 3, "resume_mid");
    @(negedge clk); run = 1'b1; drive();
    wait_cond(2, 0, 0, "resume_fs");
    check("resume_busy_dropped", busy_dropped, 0);
    check("resume_fs_hc", hc1, 0);
    check("resume_fs_vc", vc1, 0);

    // Asynchronous reset between clock edges.
    wait_cond(0, 10, 2, "areset_pos");
    #1 rst = 1'b0;
    #1 check_reset_vals("areset");
    cyc(2);
    @(negedge clk); rst = 1'b1; run = 1'b1; drive();
    wait_cond(2, 0, 0, "areset_restart");
    check("restart_hc", hc1, 0);
    check("restart_vc", vc1, 0);
    check("restart_busy", bz1, 1);

    pe_mode = 1; rand_run = 1;
    cyc(1500);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
